// File: rtl/alu_2.sv
// Single-cycle MIPS-style execution block: registered PC, branch-target adder and a
// purely combinational ALU that also produces values for external HI/LO registers.
module alu_2 #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_out,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] extend_imm,
    output logic [31:0] branch_address,
    input  logic [5:0]  opcode,
    input  logic [5:0]  functcode,
    input  logic [4:0]  shamt,
    input  logic [4:0]  rt_field,
    input  logic [15:0] immediate,
    input  logic [31:0] rs_content,
    input  logic [31:0] rt_content,
    output logic [31:0] alu_result,
    output logic        sig_branch,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] OP_RTYPE  = 6'h00, OP_REGIMM = 6'h01, OP_BEQ   = 6'h04,
                           OP_BNE    = 6'h05, OP_BLEZ   = 6'h06, OP_BGTZ  = 6'h07,
                           OP_ADDIU  = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B,
                           OP_ANDI   = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E,
                           OP_LUI    = 6'h0F, OP_MEM_LO = 6'h20, OP_MEM_HI = 6'h2E;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                           FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                           FN_MTHI = 6'h11, FN_MTLO = 6'h13, FN_MULT = 6'h18,
                           FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU = 6'h1B,
                           FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND  = 6'h24,
                           FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_SLT  = 6'h2A,
                           FN_SLTU = 6'h2B;

    logic [31:0] r_pc;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (clk_enable) begin
            r_pc <= pc_in;
        end
    end

    assign pc_out         = r_pc;
    assign branch_address = pc_plus4 + extend_imm;

    logic [31:0] w_se, w_ze;
    logic [63:0] w_mul_s, w_mul_u;
    logic [31:0] w_rs_abs, w_rt_abs, w_q_mag, w_r_mag, w_q_s, w_r_s, w_q_u, w_r_u;
    logic        w_rt_zero;

    assign w_se = {{16{immediate[15]}}, immediate};
    assign w_ze = {16'h0000, immediate};

    assign w_mul_s = $signed({{32{rs_content[31]}}, rs_content})
                   * $signed({{32{rt_content[31]}}, rt_content});
    assign w_mul_u = {32'h0, rs_content} * {32'h0, rt_content};

    // Signed divide on magnitudes keeps the -2^31 / -1 case well defined (wraps to 2^31).
    assign w_rt_zero = (rt_content == 32'h0);
    assign w_rs_abs  = rs_content[31] ? (32'h0 - rs_content) : rs_content;
    assign w_rt_abs  = rt_content[31] ? (32'h0 - rt_content) : rt_content;
    assign w_q_mag   = w_rt_zero ? 32'h0 : w_rs_abs / w_rt_abs;
    assign w_r_mag   = w_rt_zero ? 32'h0 : w_rs_abs % w_rt_abs;
    assign w_q_s     = (rs_content[31] ^ rt_content[31]) ? (32'h0 - w_q_mag) : w_q_mag;
    assign w_r_s     = rs_content[31] ? (32'h0 - w_r_mag) : w_r_mag;
    assign w_q_u     = w_rt_zero ? 32'h0 : rs_content / rt_content;
    assign w_r_u     = w_rt_zero ? 32'h0 : rs_content % rt_content;

    logic [31:0] w_alu, w_hi, w_lo;
    logic        w_branch;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_alu    = 32'h0;
        w_hi     = 32'h0;
        w_lo     = 32'h0;
        w_branch = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (functcode)
                    FN_ADDU:  w_alu = rs_content + rt_content;
                    FN_SUBU:  w_alu = rs_content - rt_content;
                    FN_AND:   w_alu = rs_content & rt_content;
                    FN_OR:    w_alu = rs_content | rt_content;
                    FN_XOR:   w_alu = rs_content ^ rt_content;
                    FN_SLT:   w_alu = {31'h0, $signed(rs_content) < $signed(rt_content)};
                    FN_SLTU:  w_alu = {31'h0, rs_content < rt_content};
                    FN_SLL:   w_alu = rt_content << shamt;
                    FN_SRL:   w_alu = rt_content >> shamt;
                    FN_SRA:   w_alu = $signed(rt_content) >>> shamt;
                    FN_SLLV:  w_alu = rt_content << rs_content[4:0];
                    FN_SRLV:  w_alu = rt_content >> rs_content[4:0];
                    FN_SRAV:  w_alu = $signed(rt_content) >>> rs_content[4:0];
                    FN_MULT:  {w_hi, w_lo} = w_mul_s;
                    FN_MULTU: {w_hi, w_lo} = w_mul_u;
                    FN_DIV:   begin w_lo = w_q_s; w_hi = w_r_s; end
                    FN_DIVU:  begin w_lo = w_q_u; w_hi = w_r_u; end
                    FN_MTHI:  w_hi = rs_content;
                    FN_MTLO:  w_lo = rs_content;
                    default:  ;
                endcase
            end
            OP_REGIMM: begin
                case (rt_field)
                    5'h00, 5'h10: w_branch = rs_content[31];
                    5'h01, 5'h11: w_branch = ~rs_content[31];
                    default:      ;
                endcase
            end
            OP_BEQ:   w_branch = (rs_content == rt_content);
            OP_BNE:   w_branch = (rs_content != rt_content);
            OP_BLEZ:  w_branch = rs_content[31] | (rs_content == 32'h0);
            OP_BGTZ:  w_branch = ~rs_content[31] & (rs_content != 32'h0);
            OP_ADDIU: w_alu = rs_content + w_se;
            OP_SLTI:  w_alu = {31'h0, $signed(rs_content) < $signed(w_se)};
            OP_SLTIU: w_alu = {31'h0, rs_content < w_se};
            OP_ANDI:  w_alu = rs_content & w_ze;
            OP_ORI:   w_alu = rs_content | w_ze;
            OP_XORI:  w_alu = rs_content ^ w_ze;
            OP_LUI:   w_alu = {immediate, 16'h0000};
            default: begin
                if (opcode >= OP_MEM_LO && opcode <= OP_MEM_HI) begin
                    w_alu = rs_content + w_se;
                end
            end
        endcase
    end

    assign alu_result = w_alu;
    assign hi         = w_hi;
    assign lo         = w_lo;
    assign sig_branch = w_branch;

endmodule

// File: tb/tb_alu_2.sv
// Self-checking bench for alu_2: PC reset/update sequences, a directed vector table and
// randomized instructions compared against a behavioural model.
module tb_alu_2;

    logic        clk = 1'b0;
    logic        reset, clk_enable;
    logic [31:0] pc_in, pc_out, pc_plus4, extend_imm, branch_address;
    logic [5:0]  opcode, functcode;
    logic [4:0]  shamt, rt_field;
    logic [15:0] immediate;
    logic [31:0] rs_content, rt_content, alu_result, hi, lo;
    logic        sig_branch;

    int checks   = 0;
    int failures = 0;

    alu_2 dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .pc_in(pc_in), .pc_out(pc_out),
        .pc_plus4(pc_plus4), .extend_imm(extend_imm), .branch_address(branch_address),
        .opcode(opcode), .functcode(functcode), .shamt(shamt), .rt_field(rt_field),
        .immediate(immediate), .rs_content(rs_content), .rt_content(rt_content),
        .alu_result(alu_result), .sig_branch(sig_branch), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        br;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [4:0]  rtf;
        logic [15:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] alu;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        br;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    logic [5:0] fn_list [20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                                 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h21, 6'h23,
                                 6'h24, 6'h25, 6'h2A, 6'h2B};
    logic [5:0] op_list [18] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h09,
                                 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h23,
                                 6'h2B, 6'h2E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: instruction semantics written with integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [4:0] sh, input logic [4:0] rtf,
                                   input logic [15:0] imm, input logic [31:0] rs,
                                   input logic [31:0] rt);
        exp_t        e;
        int signed   srs, srt, sse;
        longint      a, b, q, r, p;
        logic [63:0] pu;
        logic [31:0] se;
        e   = '0;
        srs = rs;
        srt = rt;
        se  = {{16{imm[15]}}, imm};
        sse = se;
        if (op == 6'h00) begin
            case (fn)
                6'h21: e.alu = rs + rt;
                6'h23: e.alu = rs - rt;
                6'h24: e.alu = rs & rt;
                6'h25: e.alu = rs | rt;
                6'h26: e.alu = rs ^ rt;
                6'h2A: e.alu = (srs < srt) ? 32'd1 : 32'd0;
                6'h2B: e.alu = (rs < rt) ? 32'd1 : 32'd0;
                6'h00: e.alu = rt << sh;
                6'h02: e.alu = rt >> sh;
                6'h03: e.alu = srt >>> sh;
                6'h04: e.alu = rt << rs[4:0];
                6'h06: e.alu = rt >> rs[4:0];
                6'h07: e.alu = srt >>> rs[4:0];
                6'h18: begin p = longint'(srs) * longint'(srt); {e.hi, e.lo} = p; end
                6'h19: begin pu = 64'(rs) * 64'(rt); {e.hi, e.lo} = pu; end
                6'h1A: if (rt != 0) begin
                    a = longint'(srs); b = longint'(srt);
                    q = a / b; r = a % b;
                    e.lo = 32'(q); e.hi = 32'(r);
                end
                6'h1B: if (rt != 0) begin e.lo = rs / rt; e.hi = rs % rt; end
                6'h11: e.hi = rs;
                6'h13: e.lo = rs;
                default: ;
            endcase
        end else if (op == 6'h01) begin
            if (rtf == 5'h00 || rtf == 5'h10) e.br = (srs < 0);
            if (rtf == 5'h01 || rtf == 5'h11) e.br = (srs >= 0);
        end else if (op == 6'h04) e.br = (rs == rt);
        else if (op == 6'h05) e.br = (rs != rt);
        else if (op == 6'h06) e.br = (srs <= 0);
        else if (op == 6'h07) e.br = (srs > 0);
        else if (op == 6'h09) e.alu = rs + se;
        else if (op == 6'h0A) e.alu = (srs < sse) ? 32'd1 : 32'd0;
        else if (op == 6'h0B) e.alu = (rs < se) ? 32'd1 : 32'd0;
        else if (op == 6'h0C) e.alu = rs & 32'(imm);
        else if (op == 6'h0D) e.alu = rs | 32'(imm);
        else if (op == 6'h0E) e.alu = rs ^ 32'(imm);
        else if (op == 6'h0F) e.alu = 32'(imm) * 32'h10000;
        else if (op >= 6'h20 && op <= 6'h2E) e.alu = rs + se;
        return e;
    endfunction

    task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [4:0] rtf, input logic [15:0] imm,
                         input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        opcode = op; functcode = fn; shamt = sh; rt_field = rtf;
        immediate = imm; rs_content = rs; rt_content = rt;
        #1;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        exp_t        e;
        logic [5:0]  op, fn;
        logic [4:0]  sh, rtf;
        logic [15:0] imm;
        logic [31:0] rs, rt, pp4, ext;

        reset = 1'b0; clk_enable = 1'b1; pc_in = 32'h0;
        pc_plus4 = 32'h0; extend_imm = 32'h0;
        opcode = 6'h0; functcode = 6'h0; shamt = 5'h0; rt_field = 5'h0;
        immediate = 16'h0; rs_content = 32'h0; rt_content = 32'h0;

        // PC reset and update sequences
        @(posedge clk); #1;
        check("pc_reset", pc_out, 32'hBFC00000);
        @(negedge clk);
        reset = 1'b1; pc_in = 32'hBFC00004; clk_enable = 1'b1;
        @(posedge clk); #1;
        check("pc_load", pc_out, 32'hBFC00004);
        @(negedge clk);
        clk_enable = 1'b0; pc_in = 32'h12345678;
        @(posedge clk); #1;
        check("pc_hold", pc_out, 32'hBFC00004);
        @(negedge clk);
        clk_enable = 1'b1;
        @(posedge clk); #1;
        check("pc_load2", pc_out, 32'h12345678);
        #2 reset = 1'b0;
        #1 check("pc_async_reset", pc_out, 32'hBFC00000);
        @(posedge clk); #1;
        check("pc_reset_over_edge", pc_out, 32'hBFC00000);
        @(negedge clk);
        reset = 1'b1; pc_in = 32'h00400000;
        @(posedge clk); #1;
        check("pc_after_release", pc_out, 32'h00400000);

        @(negedge clk);
        pc_plus4 = 32'hBFC00004; extend_imm = 32'hFFFFFFF8;
        #1 check("branch_address", branch_address, 32'hBFBFFFFC);

        //            op     fn     sh  rtf    imm       rs            rt            alu           hi            lo            br
        vecs[0]  = '{6'h00, 6'h21, 5'd0, 5'h00, 16'h0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{6'h00, 6'h18, 5'd0, 5'h00, 16'h0000, 32'hFFFFFFFE, 32'h00000003, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
        vecs[2]  = '{6'h00, 6'h19, 5'd0, 5'h00, 16'h0000, 32'hFFFFFFFE, 32'h00000003, 32'h0,        32'h00000002, 32'hFFFFFFFA, 1'b0};
        vecs[3]  = '{6'h00, 6'h1A, 5'd0, 5'h00, 16'h0000, 32'hFFFFFFF9, 32'h00000002, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{6'h00, 6'h1B, 5'd0, 5'h00, 16'h0000, 32'h00001234, 32'h00000000, 32'h0,        32'h0,        32'h0,        1'b0};
        vecs[5]  = '{6'h00, 6'h03, 5'd4, 5'h00, 16'h0000, 32'h00000000, 32'h80000000, 32'hF8000000, 32'h0,        32'h0,        1'b0};
        vecs[6]  = '{6'h0F, 6'h00, 5'd0, 5'h00, 16'h1234, 32'h00000000, 32'h00000000, 32'h12340000, 32'h0,        32'h0,        1'b0};
        vecs[7]  = '{6'h0D, 6'h00, 5'd0, 5'h00, 16'h8000, 32'h00000000, 32'h00000000, 32'h00008000, 32'h0,        32'h0,        1'b0};
        vecs[8]  = '{6'h04, 6'h00, 5'd0, 5'h00, 16'h0000, 32'h00000005, 32'h00000005, 32'h0,        32'h0,        32'h0,        1'b1};
        vecs[9]  = '{6'h01, 6'h00, 5'd0, 5'h01, 16'h0000, 32'h00000000, 32'h00000000, 32'h0,        32'h0,        32'h0,        1'b1};
        vecs[10] = '{6'h01, 6'h00, 5'd0, 5'h00, 16'h0000, 32'h00000000, 32'h00000000, 32'h0,        32'h0,        32'h0,        1'b0};
        vecs[11] = '{6'h07, 6'h00, 5'd0, 5'h00, 16'h0000, 32'h80000000, 32'h00000000, 32'h0,        32'h0,        32'h0,        1'b0};
        vecs[12] = '{6'h00, 6'h2A, 5'd0, 5'h00, 16'h0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0,        32'h0,        1'b0};
        vecs[13] = '{6'h00, 6'h2B, 5'd0, 5'h00, 16'h0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        32'h0,        1'b0};
        vecs[14] = '{6'h23, 6'h00, 5'd0, 5'h00, 16'hFFFC, 32'h00001000, 32'h00000000, 32'h00000FFC, 32'h0,        32'h0,        1'b0};
        vecs[15] = '{6'h00, 6'h11, 5'd0, 5'h00, 16'h0000, 32'h0000ABCD, 32'h00000000, 32'h0,        32'h0000ABCD, 32'h0,        1'b0};
        vecs[16] = '{6'h00, 6'h1A, 5'd0, 5'h00, 16'h0000, 32'h00000007, 32'hFFFFFFFE, 32'h0,        32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[17] = '{6'h02, 6'h00, 5'd0, 5'h00, 16'h0000, 32'h00000003, 32'h00000003, 32'h0,        32'h0,        32'h0,        1'b0};

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].op, vecs[i].fn, vecs[i].sh, vecs[i].rtf, vecs[i].imm, vecs[i].rs, vecs[i].rt);
            check($sformatf("vec%0d_alu", i), alu_result, vecs[i].alu);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
            check($sformatf("vec%0d_br", i), {31'h0, sig_branch}, {31'h0, vecs[i].br});
        end

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                op = 6'h00;
                fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 19)];
            end else begin
                op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_list[$urandom_range(0, 17)];
                fn = 6'($urandom);
            end
            case ($urandom_range(0, 4))
                0:       rtf = 5'h00;
                1:       rtf = 5'h01;
                2:       rtf = 5'h10;
                3:       rtf = 5'h11;
                default: rtf = 5'($urandom);
            endcase
            sh  = 5'($urandom);
            imm = 16'($urandom);
            rs  = pick_operand();
            rt  = ($urandom_range(0, 5) == 0) ? rs : pick_operand();
            pp4 = $urandom;
            ext = $urandom;
            pc_plus4 = pp4; extend_imm = ext;
            apply(op, fn, sh, rtf, imm, rs, rt);
            e = model(op, fn, sh, rtf, imm, rs, rt);
            check($sformatf("rnd%0d_op%h_fn%h_alu", i, op, fn), alu_result, e.alu);
            check($sformatf("rnd%0d_op%h_fn%h_hi", i, op, fn), hi, e.hi);
            check($sformatf("rnd%0d_op%h_fn%h_lo", i, op, fn), lo, e.lo);
            check($sformatf("rnd%0d_op%h_rtf%h_br", i, op, rtf), {31'h0, sig_branch}, {31'h0, e.br});
            check($sformatf("rnd%0d_baddr", i), branch_address, pp4 + ext);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_2.md
ALU_2 -- requirements
Module: alu_2

Interface
REQ-001 Parameter: RESET_PC, 32'hBFC00000, PC value loaded while reset is asserted.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-low.
REQ-004 clk_enable  input  1  PC update enable.
REQ-005 pc_in  input  32  next PC value.
REQ-006 pc_out  output  32  current PC (registered).
REQ-007 pc_plus4  input  32  PC+4 operand for the branch-target adder.
REQ-008 extend_imm  input  32  sign-extended immediate shifted left 2.
REQ-009 branch_address  output  32  branch target.
REQ-010 opcode  input  6  instr[31:26].
REQ-011 functcode  input  6  instr[5:0].
REQ-012 shamt  input  5  instr[10:6].
REQ-013 rt_field  input  5  instr[20:16]; selects the REGIMM branch type.
REQ-014 immediate  input  16  instr[15:0].
REQ-015 rs_content, rt_content  input  32 each  register operands.
REQ-016 alu_result  output  32  ALU result or memory address.
REQ-017 sig_branch  output  1  branch taken.
REQ-018 hi, lo  output  32 each  values for external HI/LO registers.

Function
REQ-019 pc_out SHALL load pc_in on the rising clk edge when clk_enable=1 and reset is high; otherwise pc_out holds.
REQ-020 branch_address SHALL be pc_plus4 + extend_imm, modulo 2^32, combinational.
REQ-021 All ALU outputs SHALL be combinational from the current inputs; zero latency.
REQ-022 SE = immediate sign-extended to 32 bits; ZE = immediate zero-extended.
REQ-023 R-type (opcode 0), result into alu_result:
- ADDU 0x21: rs+rt.
- SUBU 0x23: rs-rt.
- AND 0x24, OR 0x25, XOR 0x26: bitwise rs op rt.
- SLT 0x2A: signed compare; SLTU 0x2B: unsigned compare; result is 1 or 0.
- SLL 0x00, SRL 0x02, SRA 0x03: shift rt by shamt.
- SLLV 0x04, SRLV 0x06, SRAV 0x07: shift rt by rs[4:0].
- JR 0x08: alu_result = 0.
- JALR 0x09: alu_result = 0.
REQ-024 MULT 0x18 / MULTU 0x19: {hi,lo} = 64-bit signed / unsigned product of rs and rt.
REQ-025 DIV 0x1A / DIVU 0x1B: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the dividend's sign. A divisor of 0 gives hi=lo=0.
REQ-026 MTHI 0x11: hi = rs, lo = 0. MTLO 0x13: lo = rs, hi = 0.
REQ-027 For every opcode/funct not listed in REQ-024 to REQ-026, hi = lo = 0.
REQ-028 I-type ALU operations:
- ADDIU 0x09: rs+SE.
- SLTI 0x0A: signed rs<SE; SLTIU 0x0B: unsigned rs<SE.
- ANDI 0x0C, ORI 0x0D, XORI 0x0E: rs op ZE.
- LUI 0x0F: {immediate,16'h0}.
REQ-029 Loads and stores (opcodes 0x20-0x2E): alu_result = rs+SE.
REQ-030 Branch conditions for sig_branch; alu_result = 0 for all of them:
- BEQ 0x04: rs==rt.
- BNE 0x05: rs!=rt.
- BLEZ 0x06: signed rs<=0.
- BGTZ 0x07: signed rs>0.
- REGIMM 0x01, rt_field 0x00 BLTZ or 0x10 BLTZAL: rs<0.
- REGIMM 0x01, rt_field 0x01 BGEZ or 0x11 BGEZAL: rs>=0.
REQ-031 sig_branch SHALL be 0 for every non-branch instruction.
REQ-032 J 0x02, JAL 0x03 and unknown encodings: alu_result = 0, sig_branch = 0.
REQ-033 All arithmetic wraps modulo 2^32; no overflow flag, no trap.

Reset
REQ-034 reset low SHALL immediately, without waiting for clk, force pc_out = RESET_PC, regardless of clk_enable.
REQ-035 Reset SHALL have priority over any simultaneous clock edge.
REQ-036 The block has no other state; the ALU outputs do not depend on reset.

Verification
REQ-037 Reset and PC update:
- Assert reset mid-cycle -> pc_out = BFC00000 before the next edge.
- Release reset, pc_in = BFC00004, clk_enable=1, one edge -> pc_out = BFC00004.
- clk_enable=0 -> pc_out holds.
REQ-038 Arithmetic and branch target:
- ADDU, rs=FFFFFFFF, rt=1 -> alu_result = 0.
- pc_plus4 = BFC00004, extend_imm = FFFFFFF8 -> branch_address = BFBFFFFC.
REQ-039 Multiply and divide:
- MULT, rs=FFFFFFFE (-2), rt=3 -> hi = FFFFFFFF, lo = FFFFFFFA.
- MULTU with the same operands -> hi = 2, lo = FFFFFFFA.
- DIV, rs=-7, rt=2 -> lo = FFFFFFFD, hi = FFFFFFFF.
- DIVU, rt=0 -> hi = lo = 0.
REQ-040 Shifts and immediates:
- SRA, rt=80000000, shamt=4 -> F8000000.
- LUI, immediate=1234 -> 12340000.
- ORI, rs=0, immediate=8000 -> 00008000.
REQ-041 Branches:
- BEQ, rs=rt=5 -> sig_branch=1.
- BGEZ, rs=0 -> 1.
- BLTZ, rs=0 -> 0.
- BGTZ, rs=80000000 -> 0.
REQ-042 Compares and load address:
- SLT, rs=FFFFFFFF, rt=1 -> 1.
- SLTU with the same operands -> 0.
- LW, rs=1000, immediate=FFFC -> alu_result = 00000FFC.
